// File: rtl/sram_seq_ctrl.sv
// sram_seq_ctrl
//   Sequencer for the custom SRAM macro. A single-word read or write request
//   is accepted over a valid/ready handshake. The request is then played out
//   to the array as a fixed phase sequence: precharge, wordline access,
//   optional sense, and a completion pulse.
//
//   Phase table (state | meaning):
//     S_IDLE  | ready for a request, all array controls low
//     S_PRE   | bitline precharge for PRE_CYC cycles
//     S_ACT   | wordline high, write drivers on for writes, ACC_CYC cycles
//     S_SENSE | wordline + sense amp for one cycle, read data captured on exit
//     S_DONE  | one-cycle rsp_valid pulse, then back to idle
//
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     req_valid/req_ready        request handshake (ready only in S_IDLE)
//     req_op/req_addr/req_wdata  request: op 1 = write, 0 = read
//     rsp_valid/rsp_rdata/rsp_err completion pulse, read data, read parity error
//     arr_pre/arr_wl/arr_we/arr_sae  array phase controls (state decode only)
//     arr_addr/arr_wdata         latched address and write data (MSB = parity)
//     arr_rdata                  sensed data from the array (MSB = parity)
//
//   Build option: define SRAM_SEQ_PARITY_EN to store even parity on writes and
//   to flag parity errors on reads. Without it, the parity bit is written as 0,
//   ignored on reads, and rsp_err stays 0.
module sram_seq_ctrl #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 8,
    parameter int PRE_CYC = 2,
    parameter int ACC_CYC = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              arr_pre,
    output logic              arr_wl,
    output logic              arr_we,
    output logic              arr_sae,
    output logic [ADDR_W-1:0] arr_addr,
    output logic [DATA_W:0]   arr_wdata,
    input  logic [DATA_W:0]   arr_rdata
);

    localparam int MAX_CYC = (PRE_CYC > ACC_CYC) ? PRE_CYC : ACC_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ACT,
        S_SENSE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W:0]     wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                par_w;
    logic                par_r;

`ifdef SRAM_SEQ_PARITY_EN
    assign par_w = ^req_wdata;
    // Even parity over data plus stored parity bit: any odd count is an error.
    assign par_r = ^arr_rdata;
`else
    logic unused_rd_par;
    assign par_w         = 1'b0;
    assign par_r         = 1'b0;
    assign unused_rd_par = arr_rdata[DATA_W];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = S_PRE;
                    cnt_d   = CNT_W'(PRE_CYC);
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = {par_w, req_wdata};
                    // A stale read error must not ride along with a later write response.
                    err_d   = 1'b0;
                end
            end
            S_PRE: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_ACT;
                    cnt_d   = CNT_W'(ACC_CYC);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ACT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = op_q ? S_DONE : S_SENSE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_SENSE: begin
                state_d = S_DONE;
                rdata_d = arr_rdata[DATA_W-1:0];
                err_d   = par_r;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Array controls decode the state register only, so an asynchronous
    // reset drops them immediately and request inputs never reach them.
    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_DONE);
    assign arr_pre   = (state_q == S_PRE);
    assign arr_wl    = (state_q == S_ACT) || (state_q == S_SENSE);
    assign arr_we    = (state_q == S_ACT) && op_q;
    assign arr_sae   = (state_q == S_SENSE);

    assign arr_addr  = addr_q;
    assign arr_wdata = wdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_sram_seq_ctrl.sv
module tb_sram_seq_ctrl;

`ifdef SRAM_SEQ_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    localparam int PS [3] = '{2, 1, 7};
    localparam int AS [3] = '{3, 1, 5};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_op = 1'b0;
    logic [5:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic [8:0] arr_rdata = '0;

    logic [2:0] ready, rv, err, pre, wl, we, sae;
    logic [5:0] aaddr  [3];
    logic [8:0] awdata [3];
    logic [7:0] rdata  [3];

    logic [5:0] ctl0;
    assign ctl0 = {pre[0], wl[0], we[0], sae[0], rv[0], ready[0]};

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_seq_ctrl #(.ADDR_W(6), .DATA_W(8), .PRE_CYC(2), .ACC_CYC(3)) u0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready[0]),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv[0]), .rsp_rdata(rdata[0]), .rsp_err(err[0]),
        .arr_pre(pre[0]), .arr_wl(wl[0]), .arr_we(we[0]), .arr_sae(sae[0]),
        .arr_addr(aaddr[0]), .arr_wdata(awdata[0]), .arr_rdata(arr_rdata));

    sram_seq_ctrl #(.ADDR_W(6), .DATA_W(8), .PRE_CYC(1), .ACC_CYC(1)) u1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready[1]),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv[1]), .rsp_rdata(rdata[1]), .rsp_err(err[1]),
        .arr_pre(pre[1]), .arr_wl(wl[1]), .arr_we(we[1]), .arr_sae(sae[1]),
        .arr_addr(aaddr[1]), .arr_wdata(awdata[1]), .arr_rdata(arr_rdata));

    sram_seq_ctrl #(.ADDR_W(6), .DATA_W(8), .PRE_CYC(7), .ACC_CYC(5)) u2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready[2]),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv[2]), .rsp_rdata(rdata[2]), .rsp_err(err[2]),
        .arr_pre(pre[2]), .arr_wl(wl[2]), .arr_we(we[2]), .arr_sae(sae[2]),
        .arr_addr(aaddr[2]), .arr_wdata(awdata[2]), .arr_rdata(arr_rdata));

    // Leaves the bench at a falling edge with every instance idle.
    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (ready !== 3'b111 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (ready !== 3'b111) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout ready=%b required 111", ready);
        end
    endtask

    // Presents one request at the current falling edge; it is accepted at the
    // next rising edge (E0). Returns at the falling edge of cycle 1.
    task automatic issue(input bit op, input logic [5:0] addr, input logic [7:0] wd);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if (ctl0 !== 6'b000001 || err[0] !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctl ctl=%b err=%b required 000001 0", ctl0, err[0]);
        end
        n_cmp++;
        if (aaddr[0] !== 6'h00 || awdata[0] !== 9'h000 || rdata[0] !== 8'h00) begin
            n_err++;
            $display("FAIL reset_data addr=%h wdata=%h rdata=%h required 0", aaddr[0], awdata[0], rdata[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ctl0 !== 6'b000001) begin
            n_err++;
            $display("FAIL post_reset_ctl ctl=%b required 000001", ctl0);
        end
    endtask

    task automatic test_write();
        logic [5:0] e;
        wait_idle();
        issue(1'b1, 6'h05, 8'hA5);
        req_addr  = 6'h3F;
        req_wdata = 8'hFF;
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) @(negedge clk);
            e = '0;
            e[5] = (c <= 2);
            e[4] = (c >= 3 && c <= 5);
            e[3] = (c >= 3 && c <= 5);
            e[1] = (c == 6);
            e[0] = (c == 7);
            n_cmp++;
            if (ctl0 !== e) begin
                n_err++;
                $display("FAIL write_cyc%0d pre,wl,we,sae,rv,rdy=%b required %b", c, ctl0, e);
            end
            if (c == 3) begin
                n_cmp++;
                if (aaddr[0] !== 6'h05 || awdata[0] !== 9'h0A5) begin
                    n_err++;
                    $display("FAIL write_latch addr=%h wdata=%h required 05 0a5", aaddr[0], awdata[0]);
                end
            end
        end
    endtask

    task automatic test_read();
        logic [5:0] e;
        wait_idle();
        arr_rdata = 9'h0A5;
        issue(1'b0, 6'h05, 8'h00);
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) @(negedge clk);
            e = '0;
            e[5] = (c <= 2);
            e[4] = (c >= 3 && c <= 6);
            e[2] = (c == 6);
            e[1] = (c == 7);
            e[0] = (c == 8);
            n_cmp++;
            if (ctl0 !== e) begin
                n_err++;
                $display("FAIL read_cyc%0d pre,wl,we,sae,rv,rdy=%b required %b", c, ctl0, e);
            end
            if (c == 7) begin
                n_cmp++;
                if (rdata[0] !== 8'hA5 || err[0] !== 1'b0) begin
                    n_err++;
                    $display("FAIL read_data rdata=%h err=%b required a5 0", rdata[0], err[0]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc, nrsp, nrdy;
        int acc_cyc [3];
        bit ovl, just_acc;
        acc = 0; nrsp = 0; nrdy = 0; ovl = 1'b0; just_acc = 1'b0;
        acc_cyc = '{-1, -1, -1};
        wait_idle();
        arr_rdata = 9'h03C;
        req_valid = 1'b1;
        req_op    = 1'b1;
        req_addr  = 6'h01;
        req_wdata = 8'h11;
        for (int c = 0; c < 30; c++) begin
            if (c > 0) @(negedge clk);
            if (just_acc) begin
                just_acc = 1'b0;
                if (acc >= 3) req_valid = 1'b0;
                else begin
                    req_op   = ~req_op;
                    req_addr = req_addr + 6'd1;
                end
            end
            if (pre[0] && wl[0]) ovl = 1'b1;
            if (rv[0]) nrsp++;
            if (c < 22 && ready[0]) nrdy++;
            if (ready[0] && req_valid) begin
                if (acc < 3) acc_cyc[acc] = c;
                acc++;
                just_acc = 1'b1;
            end
        end
        n_cmp++;
        if (acc != 3 || acc_cyc[0] != 0 || acc_cyc[1] != 7 || acc_cyc[2] != 15) begin
            n_err++;
            $display("FAIL b2b_accept count=%0d at %0d,%0d,%0d required 3 at 0,7,15",
                     acc, acc_cyc[0], acc_cyc[1], acc_cyc[2]);
        end
        n_cmp++;
        if (nrsp != 3 || nrdy != 3 || ovl) begin
            n_err++;
            $display("FAIL b2b_shape rsp=%0d ready_cycles=%0d overlap=%0d required 3 3 0", nrsp, nrdy, ovl);
        end
    endtask

    task automatic test_parity();
        wait_idle();
        issue(1'b1, 6'h02, 8'h07);
        n_cmp++;
        if (awdata[0] !== {PAR, 8'h07}) begin
            n_err++;
            $display("FAIL parity_wdata wdata=%h required %h", awdata[0], {PAR, 8'h07});
        end
        wait_idle();
        arr_rdata = 9'h106;
        issue(1'b0, 6'h02, 8'h00);
        for (int c = 2; c <= 7; c++) @(negedge clk);
        n_cmp++;
        if ({rv[0], err[0]} !== {1'b1, PAR} || rdata[0] !== 8'h06) begin
            n_err++;
            $display("FAIL parity_read rv,err=%b%b rdata=%h required 1%b 06", rv[0], err[0], rdata[0], PAR);
        end
    endtask

    task automatic test_sweep(input bit wr, input logic [8:0] rd);
        int lat [3];
        lat = '{0, 0, 0};
        wait_idle();
        arr_rdata = rd;
        issue(wr, 6'h0A, 8'h3C);
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            for (int i = 0; i < 3; i++)
                if (rv[i] && lat[i] == 0) lat[i] = c;
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (lat[i] != PS[i] + AS[i] + (wr ? 1 : 2)) begin
                n_err++;
                $display("FAIL sweep_%s_P%0dA%0d latency=%0d required %0d", wr ? "wr" : "rd",
                         PS[i], AS[i], lat[i], PS[i] + AS[i] + (wr ? 1 : 2));
            end
            if (!wr) begin
                n_cmp++;
                if (rdata[i] !== rd[7:0]) begin
                    n_err++;
                    $display("FAIL sweep_rdata_P%0dA%0d rdata=%h required %h", PS[i], AS[i], rdata[i], rd[7:0]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_op();
        int nrsp;
        nrsp = 0;
        wait_idle();
        arr_rdata = 9'h0A5;
        issue(1'b0, 6'h07, 8'h00);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (wl[0] !== 1'b1) begin
            n_err++;
            $display("FAIL abort_pre_wl wl=%b required 1", wl[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (ctl0 !== 6'b000001 || err[0] !== 1'b0) begin
            n_err++;
            $display("FAIL abort_ctl ctl=%b err=%b required 000001 0", ctl0, err[0]);
        end
        n_cmp++;
        if (aaddr[0] !== 6'h00 || awdata[0] !== 9'h000 || rdata[0] !== 8'h00) begin
            n_err++;
            $display("FAIL abort_data addr=%h wdata=%h rdata=%h required 0", aaddr[0], awdata[0], rdata[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (rv[0]) nrsp++;
        end
        n_cmp++;
        if (nrsp != 0) begin
            n_err++;
            $display("FAIL abort_no_rsp pulses=%0d required 0", nrsp);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_parity();
        test_sweep(1'b1, 9'h000);
        test_sweep(1'b0, 9'h05A);
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sram_seq_ctrl.md
# sram_seq_ctrl

Parametrised sequencer for the custom SRAM macro. It accepts single-word read and write requests over a valid/ready handshake and drives the array's precharge, wordline, write-enable and sense-amp controls through a fixed, configurable phase sequence. It returns read data with a one-cycle response pulse. It sits between the digital core and the analog array and generalises the earlier combinational op/select controller: it adds clocked phases, configurable widths, programmable phase lengths and optional parity.

## Interface
Parameters:
- `ADDR_W`, 6: array address width.
- `DATA_W`, 8: data word width.
- `PRE_CYC`, 2: precharge phase length in cycles, ≥1.
- `ACC_CYC`, 3: wordline/access phase length in cycles, ≥1.

Ports:
- `clk`  in  1: the single clock; all state changes on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: controller can accept a request.
- `req_op`  in  1: request type; 1 = write, 0 = read.
- `req_addr`  in  ADDR_W: word address.
- `req_wdata`  in  DATA_W: write data.
- `rsp_valid`  out  1: one-cycle completion pulse, for reads and writes.
- `rsp_rdata`  out  DATA_W: read data, valid while `rsp_valid` is high on a read.
- `rsp_err`  out  1: parity error on a read, qualified by `rsp_valid`.
- `arr_pre`  out  1: bitline precharge.
- `arr_wl`  out  1: wordline enable.
- `arr_we`  out  1: write drivers enable.
- `arr_sae`  out  1: sense-amp enable.
- `arr_addr`  out  ADDR_W: latched address.
- `arr_wdata`  out  DATA_W+1: latched write data; MSB is the parity bit.
- `arr_rdata`  in  DATA_W+1: sensed data; MSB is the parity bit.

## Operation
- **States:** IDLE, PRE, ACT, SENSE, DONE.
- **Acceptance:** `req_ready` is 1 only in IDLE. A request is accepted on a rising edge where `req_valid && req_ready`. On acceptance, `req_op`, `req_addr` and `req_wdata` are latched and the FSM moves IDLE→PRE.
- **PRE:** `arr_pre`=1 for exactly PRE_CYC cycles, then →ACT.
- **ACT:** `arr_wl`=1, and `arr_we`=latched op, for exactly ACC_CYC cycles. Then a read goes →SENSE and a write goes →DONE.
- **SENSE:** `arr_wl`=1 and `arr_sae`=1 for 1 cycle. `arr_rdata` is captured into `rsp_rdata` on the edge that leaves SENSE. Then →DONE.
- **DONE:** `rsp_valid`=1 for 1 cycle, then →IDLE unconditionally. There is no response backpressure.
- **Phase counter:**
  - Width is $clog2(max(PRE_CYC,ACC_CYC)+1).
  - Loaded on each phase entry and decremented each cycle; the phase exits when the counter reaches 1.
- **Control outputs:**
  - `arr_*` controls are decoded from the state register only, with no combinational path from request inputs.
  - `arr_pre` and `arr_wl` are never high in the same cycle.
- **Data hold:**
  - `arr_addr` and `arr_wdata` hold their latched values from acceptance until the next acceptance.
  - `rsp_rdata` holds until the next read capture.
- **Ignored inputs:** `req_*` changes outside IDLE are ignored.

## Timing
- **Reset values:**
  - State = IDLE and the counter is cleared.
  - `req_ready`=1.
  - `rsp_valid`, `rsp_err`, `arr_pre`, `arr_wl`, `arr_we`, `arr_sae` = 0.
  - `arr_addr`, `arr_wdata`, `rsp_rdata` = 0.
- **Cycle numbering:** take the acceptance edge as E0.
  - PRE occupies cycles 1..P.
  - ACT occupies cycles P+1..P+A.
  - Read: SENSE is cycle P+A+1, DONE is cycle P+A+2.
  - Write: DONE is cycle P+A+1.
- **Re-acceptance:** the next request can be accepted no earlier than the edge ending the IDLE cycle after DONE.
  - Read period: P+A+3 cycles.
  - Write period: P+A+2 cycles.
- **Reset mid-operation:** asserting `rst_n` low in any state immediately (asynchronously) forces every output to its reset value, including dropping `arr_wl`. The aborted request produces no response.
- **Request held through a transaction:** a `req_valid` held high across a transaction is accepted once per IDLE visit, never twice per transaction.

## Configuration
- **`SRAM_SEQ_PARITY_EN` defined:**
  - Writes store even parity: `arr_wdata[DATA_W]` = ^`req_wdata`.
  - Reads set `rsp_err` = (^`arr_rdata`) at the SENSE capture edge.
- **`SRAM_SEQ_PARITY_EN` undefined:**
  - `arr_wdata[DATA_W]`=0.
  - `arr_rdata[DATA_W]` is ignored.
  - `rsp_err` is tied 0.
- **Common to both:** the port list is identical either way.

## Test plan
All scenarios use P=2, A=3, DATA_W=8.
- **Reset:** reset, then release → `req_ready`=1 and all other outputs 0. Assert `rst_n`=0 during ACT → `arr_wl` falls without waiting for an edge, and no `rsp_valid` follows.
- **Write:** write addr 0x05, data 0xA5 → `arr_pre` high in cycles 1–2; `arr_wl`=`arr_we`=1 in cycles 3–5; `rsp_valid` in cycle 6; `req_ready` high again in cycle 7.
- **Read:** read addr 0x05 with array model returning 0x0A5 → `arr_sae` high only in cycle 6; `rsp_valid` with `rsp_rdata`=0xA5 in cycle 7; `arr_we` never high.
- **Back-to-back:** `req_valid` held high for 3 alternating write/read requests → each accepted exactly once; `arr_pre` and `arr_wl` never overlap; `req_ready` low throughout each transaction.
- **Parity, macro defined:** write 0x07 → `arr_wdata`=0x107. Read where the array returns 0x106 → `rsp_err`=1 with `rsp_valid`.
- **Parity, macro undefined:** same read → `rsp_err`=0.
- **Phase-length sweep:** repeat the write/read scenarios with P=1, A=1 and with P=7, A=5 → latencies equal P+A+1 (write) and P+A+2 (read) exactly.
